puf_eval_ctrl: RTL and testbench
================================

// Module: puf_eval_ctrl
// PURPOSE
//  Sequencer that drives the arbiter PUF: accepts a challenge, runs EVALS clear/launch/sample
//  cycles, majority-votes each response bit, and returns a voted response plus an instability mask.
//  Sits between the system command interface and the PUF primitive. Owns puf_reset, puf_enable
//  and puf_challenge, and synchronises puf_resp into the clk domain.
// PARAMETERS
//  C_BITS        4  challenge width, equal to the PUF C_BITS
//  R_BITS        4  response width, equal to the PUF R_BITS
//  SETTLE_CYCLES 8  cycles puf_enable is held high before sampling; must be >=3
//  EVALS         5  evaluations per challenge; odd, >=1
//  CNT_W  $clog2(EVALS+1)  per-bit ones-counter width (derived, localparam)
// PORTS
//  clk           in   1       system clock
//  reset         in   1       asynchronous, active-high reset
//  cmd_valid     in   1       challenge request valid
//  cmd_ready     out  1       high only in IDLE
//  cmd_challenge in   C_BITS  challenge, latched on accept
//  rsp_valid     out  1       voted result valid
//  rsp_ready     in   1       consumer accepts result
//  rsp_data      out  R_BITS  majority-voted response
//  rsp_flip      out  R_BITS  bit set = that bit was not unanimous across EVALS
//  busy          out  1       high in every state except IDLE
//  puf_reset     out  1       to PUF reset; = reset OR (state==CLEAR)
//  puf_enable    out  1       to PUF enable; registered, high only in LAUNCH
//  puf_challenge out  C_BITS  latched challenge, stable for the whole operation
//  puf_resp      in   R_BITS  PUF output, asynchronous; 2-flop synchroniser per bit
// BEHAVIOUR
//  Reset values: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; rsp_flip=0; busy=0;
//   puf_enable=0; puf_challenge=0; counters=0; sync flops=0. puf_reset=1 while reset is high.
//  States: IDLE -> CLEAR -> LAUNCH -> SAMPLE -> (CLEAR | VOTE) -> DONE -> IDLE.
//  IDLE: on cmd_valid&&cmd_ready, latch challenge, clear ones-counters and eval count, go to CLEAR.
//  CLEAR: 1 cycle; puf_reset=1, puf_enable=0.
//  LAUNCH: exactly SETTLE_CYCLES cycles, puf_enable=1. Settle counter reloads on entry.
//  SAMPLE: 1 cycle, puf_enable=0. For each bit b, ones[b] += sync_resp[b].
//   Then eval count +1. Go to VOTE if count==EVALS, else go to CLEAR.
//  VOTE: 1 cycle. rsp_data[b] = (ones[b] > EVALS/2).
//   rsp_flip[b] = (ones[b]!=0 && ones[b]!=EVALS). Both are registered on VOTE exit.
//  DONE: rsp_valid=1. rsp_data and rsp_flip are held stable until rsp_ready; then go to IDLE.
//  Latency: accept edge to first rsp_valid cycle = EVALS*(SETTLE_CYCLES+2)+1 clk.
//   Defaults give 51 clk.
//  Backpressure: rsp_ready low holds DONE indefinitely. cmd_ready=0 there.
//   cmd_valid outside IDLE is ignored and never queued.
//  cmd_challenge changes after accept have no effect. puf_challenge changes only on accept.
//  rsp_ready without rsp_valid has no effect. No accept occurs on the DONE->IDLE cycle.
//  Counters never overflow: CNT_W holds EVALS. Eval count stops at EVALS.
//  Reset mid-operation (any state): immediate return to reset values.
//   puf_enable drops asynchronously. The partial vote is discarded and no rsp_valid is produced.
//  EVALS=1: rsp_data = single sample; rsp_flip always 0.
// TESTING (SETTLE_CYCLES=8, EVALS=5, bench PUF model returns programmable puf_resp)
//  1 Assert reset mid-run, hold 3 clk -> all outputs at reset values, puf_reset=1 throughout.
//  2 Challenge 4'b1010, PUF constant 4'b0110 -> rsp_data=0110, rsp_flip=0000,
//    rsp_valid 51 clk after accept, puf_challenge=1010, puf_enable high 8 clk per eval x5.
//  3 Bit0 returns 1 on evals 1,3,5 only, others 0 -> rsp_data=0001, rsp_flip=0001.
//    Bit0 on evals 2,4 only -> rsp_data=0000, rsp_flip=0001.
//  4 rsp_ready low 20 clk after rsp_valid, cmd_valid pulsed meanwhile -> data held,
//    cmd_ready=0, no second op. rsp_ready=1 -> IDLE next clk, cmd_ready=1.
//  5 reset pulsed during 3rd LAUNCH -> puf_enable=0 immediately, no rsp_valid. New cmd
//    4'b0011 with PUF=4'b1111 -> rsp_data=1111, rsp_flip=0000 (no stale counts).
//  6 Back-to-back cmds 4'b0001 then 4'b1000, rsp_ready tied high -> two results 51 clk
//    apart from each accept, second accept exactly 1 clk after first handshake.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - arbiter PUF sequencer: repeated clear/launch/sample, per-bit majority vote
// and instability mask, with a 2-flop synchroniser on the asynchronous PUF response.
module puf_eval_ctrl #(
    parameter int C_BITS        = 4,
    parameter int R_BITS        = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int EVALS         = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [C_BITS-1:0] cmd_challenge_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [R_BITS-1:0] rsp_data_o,
    output logic [R_BITS-1:0] rsp_flip_o,
    output logic              busy_o,
    output logic              puf_reset_o,
    output logic              puf_enable_o,
    output logic [C_BITS-1:0] puf_challenge_o,
    input  logic [R_BITS-1:0] puf_resp_i
);

    localparam int CNT_W = $clog2(EVALS + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CNT_W-1:0] EVALS_C  = CNT_W'(EVALS);
    localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(EVALS / 2);
    localparam logic [SET_W-1:0] SETTLE_C = SET_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_VOTE   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [C_BITS-1:0] chal_q, chal_d;
    logic [CNT_W-1:0]  ones_q [R_BITS];
    logic [CNT_W-1:0]  ones_d [R_BITS];
    logic [CNT_W-1:0]  eval_q, eval_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [R_BITS-1:0] sync1_q, sync2_q;
    logic [R_BITS-1:0] data_q, data_d;
    logic [R_BITS-1:0] flip_q, flip_d;
    logic              enable_q;

    always_comb begin
        state_d  = state_q;
        chal_d   = chal_q;
        ones_d   = ones_q;
        eval_d   = eval_q;
        settle_d = settle_q;
        data_d   = data_q;
        flip_d   = flip_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    chal_d = cmd_challenge_i;
                    for (int b = 0; b < R_BITS; b++) ones_d[b] = '0;
                    eval_d  = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // CLEAR is the only way into LAUNCH, so reloading here equals reload-on-entry
                settle_d = SETTLE_C;
                state_d  = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (settle_q == '0) state_d = S_SAMPLE;
                else                settle_d = settle_q - SET_W'(1);
            end
            S_SAMPLE: begin
                for (int b = 0; b < R_BITS; b++) ones_d[b] = ones_q[b] + CNT_W'(sync2_q[b]);
                eval_d  = eval_q + CNT_W'(1);
                state_d = (eval_d == EVALS_C) ? S_VOTE : S_CLEAR;
            end
            S_VOTE: begin
                for (int b = 0; b < R_BITS; b++) begin
                    data_d[b] = (ones_q[b] > HALF_C);
                    flip_d[b] = (ones_q[b] != '0) && (ones_q[b] != EVALS_C);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            chal_q   <= '0;
            for (int b = 0; b < R_BITS; b++) ones_q[b] <= '0;
            eval_q   <= '0;
            settle_q <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            data_q   <= '0;
            flip_q   <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            chal_q   <= chal_d;
            ones_q   <= ones_d;
            eval_q   <= eval_d;
            settle_q <= settle_d;
            sync1_q  <= puf_resp_i;
            sync2_q  <= sync1_q;
            data_q   <= data_d;
            flip_q   <= flip_d;
            enable_q <= (state_d == S_LAUNCH);
        end
    end

    assign cmd_ready_o     = (state_q == S_IDLE);
    assign busy_o          = (state_q != S_IDLE);
    assign rsp_valid_o     = (state_q == S_DONE);
    assign rsp_data_o      = data_q;
    assign rsp_flip_o      = flip_q;
    assign puf_reset_o     = reset_i | (state_q == S_CLEAR);
    assign puf_enable_o    = enable_q;
    assign puf_challenge_o = chal_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - randomized bench for puf_eval_ctrl with a timeline model of one operation
// and a programmable PUF that presents one response per launch.
module tb_puf_eval_ctrl;

    localparam int SET = 8;
    localparam int EV  = 5;
    localparam int PER = SET + 2;
    localparam int LAT = EV * PER + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       rsp_ready = 1'b0;
    logic [3:0] cmd_challenge = 4'h0;
    logic [3:0] puf_resp = 4'h0;
    logic       cmd_ready, rsp_valid, busy, puf_reset, puf_enable;
    logic [3:0] rsp_data, rsp_flip, puf_challenge;

    always #5 clk = ~clk;

    puf_eval_ctrl #(.C_BITS(4), .R_BITS(4), .SETTLE_CYCLES(SET), .EVALS(EV)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_challenge_i(cmd_challenge),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_flip_o(rsp_flip), .busy_o(busy),
        .puf_reset_o(puf_reset), .puf_enable_o(puf_enable),
        .puf_challenge_o(puf_challenge), .puf_resp_i(puf_resp)
    );

    int vecs = 0;
    int errs = 0;
    logic [3:0] seq [EV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] vote();
        logic [3:0] d, f;
        int n;
        d = '0; f = '0;
        for (int b = 0; b < 4; b++) begin
            n = 0;
            for (int i = 0; i < EV; i++) n += int'(seq[i][b]);
            d[b] = (n > EV / 2);
            f[b] = (n != 0) && (n != EV);
        end
        return {d, f};
    endfunction

    // Model: an operation is just "cycles elapsed since accept"; phase follows from arithmetic.
    bit         m_busy = 1'b0;
    int         m_e = 0;
    logic [3:0] m_chal = 4'h0;
    logic [3:0] m_data = 4'h0, m_flip = 4'h0;
    int         cyc = 0, last_acc = 0, last_hs = 0, acc_n = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_e    <= 0;
            m_chal <= 4'h0;
        end else begin
            cyc <= cyc + 1;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy           <= 1'b1;
                    m_e              <= 0;
                    m_chal           <= cmd_challenge;
                    {m_data, m_flip} <= vote();
                    last_acc         <= cyc + 1;
                    acc_n            <= acc_n + 1;
                end
            end else if (m_e >= LAT && rsp_ready) begin
                m_busy  <= 1'b0;
                last_hs <= cyc + 1;
            end else begin
                m_e <= m_e + 1;
            end
        end
    end

    bit chk_on = 1'b0;
    bit e_en, e_prst, e_valid;

    always @(negedge clk) begin
        if (chk_on) begin
            e_valid = m_busy && (m_e >= LAT);
            e_en    = m_busy && (m_e < EV * PER) && (m_e % PER >= 1) && (m_e % PER <= SET);
            e_prst  = reset || (m_busy && (m_e < EV * PER) && (m_e % PER == 0));
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, e_valid);
            chk("puf_enable", puf_enable, e_en);
            chk("puf_reset", puf_reset, e_prst);
            chk("puf_challenge", puf_challenge, m_chal);
            if (e_valid) begin
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_flip", rsp_flip, m_flip);
            end
            if (reset) begin
                chk("rst_data", rsp_data, 0);
                chk("rst_flip", rsp_flip, 0);
            end
        end
    end

    // PUF stand-in: noise while held in reset, seq[k] from the k-th launch onward.
    bit en_prev = 1'b0;
    int pk = 0, en_cnt = 0;

    always @(negedge clk) begin
        en_prev <= puf_enable;
        if (cmd_valid && cmd_ready) begin
            pk     <= 0;
            en_cnt <= 0;
        end else begin
            if (puf_enable) en_cnt <= en_cnt + 1;
            if (puf_enable && !en_prev) begin
                puf_resp <= (pk < EV) ? seq[pk] : 4'h0;
                pk       <= pk + 1;
            end else if (puf_reset) begin
                puf_resp <= 4'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seq(input logic [3:0] v);
        for (int i = 0; i < EV; i++) seq[i] = v;
    endtask

    task automatic issue(input logic [3:0] ch);
        int n = 0;
        while (!cmd_ready && n < 300) begin tick(); n++; end
        chk("ready_timeout", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_challenge = ch;
        tick();
        cmd_valid = 1'b0;
        cmd_challenge = 4'($urandom);
        chk("chal_latched", puf_challenge, ch);
    endtask

    task automatic wait_rsp(input bit rnd, output int lat);
        int n = 0;
        while (!rsp_valid && n < 300) begin
            if (rnd) rsp_ready = 1'($urandom);
            tick();
            n++;
        end
        if (rnd) rsp_ready = 1'b0;
        chk("rsp_timeout", rsp_valid, 1);
        lat = cyc - last_acc;
    endtask

    task automatic release_rsp(input int hold);
        repeat (hold) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int lat, a1, an0, n;

    initial begin
        set_seq(4'h0);
        #1 reset = 1'b1;
        #2 chk_on = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // constant PUF
        set_seq(4'b0110);
        issue(4'b1010);
        wait_rsp(1'b0, lat);
        chk("t2_latency", lat, 51);
        chk("t2_data", rsp_data, 4'b0110);
        chk("t2_flip", rsp_flip, 4'b0000);
        chk("t2_enable_cycles", en_cnt, 40);
        chk("t2_challenge", puf_challenge, 4'b1010);
        release_rsp(0);

        // bit0 high on evals 1,3,5
        set_seq(4'b0000); seq[0] = 4'b0001; seq[2] = 4'b0001; seq[4] = 4'b0001;
        issue(4'($urandom));
        wait_rsp(1'b1, lat);
        chk("t3a_data", rsp_data, 4'b0001);
        chk("t3a_flip", rsp_flip, 4'b0001);
        release_rsp(2);

        // bit0 high on evals 2,4
        set_seq(4'b0000); seq[1] = 4'b0001; seq[3] = 4'b0001;
        issue(4'($urandom));
        wait_rsp(1'b1, lat);
        chk("t3b_data", rsp_data, 4'b0000);
        chk("t3b_flip", rsp_flip, 4'b0001);
        release_rsp(1);

        // backpressure with ignored commands
        set_seq(4'b1001);
        issue(4'b0111);
        wait_rsp(1'b0, lat);
        for (int i = 0; i < 20; i++) begin
            cmd_valid = (i % 3 == 0);
            cmd_challenge = 4'($urandom);
            tick();
            chk("t4_hold_data", rsp_data, 4'b1001);
            chk("t4_ready_low", cmd_ready, 0);
            chk("t4_valid_held", rsp_valid, 1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t4_idle_ready", cmd_ready, 1);
        chk("t4_idle_busy", busy, 0);
        chk("t4_challenge_kept", puf_challenge, 4'b0111);

        // reset mid-run, held 3 clk
        set_seq(4'($urandom));
        issue(4'b1100);
        repeat (23) tick();
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_busy", busy, 0);
            chk("t1_ready", cmd_ready, 1);
            chk("t1_valid", rsp_valid, 0);
            chk("t1_enable", puf_enable, 0);
            chk("t1_puf_reset", puf_reset, 1);
            chk("t1_challenge", puf_challenge, 0);
            chk("t1_data", rsp_data, 0);
        end
        reset = 1'b0;
        tick();

        // reset pulse in the third launch, then a clean op must not see stale counts
        set_seq(4'b0101);
        issue(4'b1110);
        n = 0;
        while (pk < 3 && n < 100) begin tick(); n++; end
        tick(); tick();
        chk("t5_enable_pre", puf_enable, 1);
        reset = 1'b1;
        #1;
        chk("t5_enable_async", puf_enable, 0);
        chk("t5_puf_reset", puf_reset, 1);
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin tick(); if (rsp_valid) n++; end
        chk("t5_no_rsp", n, 0);
        set_seq(4'b1111);
        issue(4'b0011);
        wait_rsp(1'b1, lat);
        chk("t5_data", rsp_data, 4'b1111);
        chk("t5_flip", rsp_flip, 4'b0000);
        release_rsp(0);

        // back-to-back with rsp_ready tied high
        set_seq(4'b1011);
        rsp_ready = 1'b1;
        an0 = acc_n;
        issue(4'b0001);
        a1 = last_acc;
        cmd_valid = 1'b1;
        cmd_challenge = 4'b1000;
        n = 0;
        while (acc_n < an0 + 2 && n < 300) begin tick(); n++; end
        cmd_valid = 1'b0;
        chk("t6_gap", last_acc - last_hs, 1);
        chk("t6_span", last_acc - a1, 53);
        chk("t6_challenge", puf_challenge, 4'b1000);
        wait_rsp(1'b0, lat);
        chk("t6_latency", lat, 51);
        chk("t6_data", rsp_data, 4'b1011);
        chk("t6_flip", rsp_flip, 4'b0000);
        tick();
        rsp_ready = 1'b0;

        // randomized operations with noisy responses
        for (int k = 0; k < 25; k++) begin
            logic [3:0] base;
            base = 4'($urandom);
            for (int i = 0; i < EV; i++)
                seq[i] = base ^ (($urandom % 3 == 0) ? 4'($urandom) : 4'h0);
            issue(4'($urandom));
            wait_rsp(1'b1, lat);
            chk("rnd_latency", lat, LAT);
            release_rsp($urandom_range(0, 4));
            repeat ($urandom_range(0, 3)) begin
                rsp_ready = 1'($urandom);
                tick();
            end
            rsp_ready = 1'b0;
        end

        tick();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

endmodule
